// File: rtl/nyq_i2s_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nyq_i2s_tx_if : parameter-write, sample-in and I2S-out bundle     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface nyq_i2s_tx_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24
);
    logic                  WrEn_SI;
    logic [ADDR_WIDTH-1:0] Addr_DI;
    logic [MEM_WIDTH-1:0]  PAR_In_DI;
    logic [IN_WIDTH-1:0]   Smp_In_DI;
    logic                  Smp_Vld_SI;
    logic                  Bclk_CO;
    logic                  Lrck_CO;
    logic                  Sdat_DO;
    logic                  Ovf_SO;
    logic                  Udf_SO;

    modport master (
        output WrEn_SI, Addr_DI, PAR_In_DI, Smp_In_DI, Smp_Vld_SI,
        input  Bclk_CO, Lrck_CO, Sdat_DO, Ovf_SO, Udf_SO
    );

    modport slave (
        input  WrEn_SI, Addr_DI, PAR_In_DI, Smp_In_DI, Smp_Vld_SI,
        output Bclk_CO, Lrck_CO, Sdat_DO, Ovf_SO, Udf_SO
    );
endinterface
`default_nettype wire

// File: rtl/nyq_i2s_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nyq_i2s_tx : one-entry sample buffer + BCLK divider + I2S framer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module nyq_i2s_tx #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic         Clk_CI,
    input  logic         Rst_RI,
    nyq_i2s_tx_if.slave  bus
);
    localparam int c_BW    = $clog2(2 * SLOT_WIDTH);
    localparam int c_IDX_W = $clog2(IN_WIDTH);

    localparam logic [c_BW-1:0] c_B_LAST = c_BW'(2 * SLOT_WIDTH - 1);
    localparam logic [c_BW-1:0] c_B_IDLE = c_BW'(2 * SLOT_WIDTH - 2);
    localparam logic [c_BW-1:0] c_LR_LO  = c_BW'(SLOT_WIDTH - 2);
    localparam logic [c_BW-1:0] c_LR_HI  = c_BW'(2 * SLOT_WIDTH - 3);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_DIV  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CLR  = ADDR_WIDTH'(2);

    logic [7:0]          div_q,  div_d;
    logic                en_q,   en_d;
    logic                mute_q, mute_d;
    logic [7:0]          dcnt_q, dcnt_d;
    logic [c_BW-1:0]     b_q,    b_d;
    logic                bclk_q, bclk_d;
    logic                lrck_q, lrck_d;
    logic                sdat_q, sdat_d;
    logic [IN_WIDTH-1:0] hr_q,   hr_d;
    logic [IN_WIDTH-1:0] fr_q,   fr_d;
    logic                full_q, full_d;
    logic                ovf_q,  ovf_d;
    logic                udf_q,  udf_d;

    logic w_clr;
    logic w_fall;
    logic w_load;
    int   w_k;
    logic w_unused_par;

    // Only the low byte of a parameter word carries fields.
    assign w_unused_par = ^bus.PAR_In_DI[MEM_WIDTH-1:8];

    always_comb begin
        div_d  = div_q;
        en_d   = en_q;
        mute_d = mute_q;
        w_clr  = 1'b0;
        if (bus.WrEn_SI) begin
            if (bus.Addr_DI == c_ADDR_DIV) begin
                div_d = bus.PAR_In_DI[7:0];
            end
            if (bus.Addr_DI == c_ADDR_CTRL) begin
                en_d   = bus.PAR_In_DI[0];
                mute_d = bus.PAR_In_DI[1];
            end
            if (bus.Addr_DI == c_ADDR_CLR) begin
                w_clr = 1'b1;
            end
        end
    end

    always_comb begin
        dcnt_d = dcnt_q;
        b_d    = b_q;
        bclk_d = bclk_q;
        lrck_d = lrck_q;
        sdat_d = sdat_q;
        hr_d   = hr_q;
        fr_d   = fr_q;
        full_d = full_q;
        ovf_d  = w_clr ? 1'b0 : ovf_q;
        udf_d  = w_clr ? 1'b0 : udf_q;
        w_fall = 1'b0;
        w_load = 1'b0;
        w_k    = 0;

        if (!en_q) begin
            dcnt_d = 8'd0;
            b_d    = c_B_IDLE;
            bclk_d = 1'b0;
            lrck_d = 1'b0;
            sdat_d = 1'b0;
            fr_d   = '0;
            full_d = 1'b0;
        end else begin
            if (dcnt_q == div_q) begin
                dcnt_d = 8'd0;
                bclk_d = ~bclk_q;
                w_fall = bclk_q;
            end else begin
                dcnt_d = dcnt_q + 8'd1;
            end

            if (w_fall) begin
                b_d    = (b_q == c_B_LAST) ? '0 : b_q + c_BW'(1);
                w_load = (b_d == c_B_LAST);
                lrck_d = (b_d >= c_LR_LO) && (b_d <= c_LR_HI);
            end

            if (w_load) begin
                if (full_q) begin
                    fr_d   = hr_q;
                    full_d = 1'b0;
                end else begin
                    udf_d = 1'b1;
                end
            end

            // A strobe coinciding with a frame load refills the emptied buffer.
            if (bus.Smp_Vld_SI) begin
                hr_d   = bus.Smp_In_DI;
                full_d = 1'b1;
                if (full_q && !w_load) begin
                    ovf_d = 1'b1;
                end
            end

            if (w_fall) begin
                w_k = (int'(b_d) + 1) % SLOT_WIDTH;
                if (w_k < IN_WIDTH) begin
                    sdat_d = fr_d[c_IDX_W'(IN_WIDTH - 1 - w_k)];
                end else begin
                    sdat_d = 1'b0;
                end
            end

            if (mute_q) begin
                sdat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            div_q  <= 8'd0;
            en_q   <= 1'b0;
            mute_q <= 1'b0;
            dcnt_q <= 8'd0;
            b_q    <= c_B_IDLE;
            bclk_q <= 1'b0;
            lrck_q <= 1'b0;
            sdat_q <= 1'b0;
            hr_q   <= '0;
            fr_q   <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            en_q   <= en_d;
            mute_q <= mute_d;
            dcnt_q <= dcnt_d;
            b_q    <= b_d;
            bclk_q <= bclk_d;
            lrck_q <= lrck_d;
            sdat_q <= sdat_d;
            hr_q   <= hr_d;
            fr_q   <= fr_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign bus.Bclk_CO = bclk_q;
    assign bus.Lrck_CO = lrck_q;
    assign bus.Sdat_DO = sdat_q;
    assign bus.Ovf_SO  = ovf_q;
    assign bus.Udf_SO  = udf_q;

endmodule
`default_nettype wire
